// File: rtl/frame_buffer_swap.sv
// Ping-pong frame buffer controller: writes rendered pixels into the back bank,
// reads the front bank with x4 nearest-neighbour upscale, swaps at vertical blank.
module frame_buffer_swap #(
    parameter int unsigned PIXEL_WIDTH        = 16,
    parameter int unsigned SCREEN_WIDTH       = 320,
    parameter int unsigned SCREEN_HEIGHT      = 180,
    parameter int unsigned FULL_SCREEN_WIDTH  = 1280,
    parameter int unsigned FULL_SCREEN_HEIGHT = 720,
    parameter int unsigned SCALE_SHIFT        = 2,
    parameter int unsigned RD_LATENCY         = 2
) (
    input  logic                   pixel_clk_in,
    input  logic                   rst_in,
    input  logic                   ray_valid_in,
    input  logic [15:0]            ray_address_in,
    input  logic [PIXEL_WIDTH-1:0] ray_pixel_in,
    input  logic                   ray_last_pixel_in,
    output logic                   frame_buff_ready_out,
    input  logic [10:0]            hcount_in,
    input  logic [9:0]             vcount_in,
    output logic                   wr_en_a_out,
    output logic                   wr_en_b_out,
    output logic [15:0]            wr_addr_out,
    output logic [PIXEL_WIDTH-1:0] wr_data_out,
    output logic [15:0]            rd_addr_out,
    input  logic [PIXEL_WIDTH-1:0] rd_data_a_in,
    input  logic [PIXEL_WIDTH-1:0] rd_data_b_in,
    output logic [PIXEL_WIDTH-1:0] pixel_out,
    output logic                   display_sel_out,
    output logic [7:0]             frame_count_out,
    output logic                   drop_flag_out
);

    localparam int unsigned FRAME_PIXELS = SCREEN_WIDTH * SCREEN_HEIGHT;
    localparam int unsigned EXT_W        = 18;

    localparam logic [0:0] WRITING   = 1'b0;
    localparam logic [0:0] WAIT_SWAP = 1'b1;

    logic [0:0] state;
    logic [0:0] state_next;

    logic       in_range_c;
    logic       swap_event_c;
    logic       accept_c;
    logic       drop_c;
    logic       ready_next;
    logic       sel_next;
    logic [7:0] count_next;

    logic        active_c;
    logic [15:0] rd_addr_c;

    logic [RD_LATENCY:0] act_pipe;
    logic [RD_LATENCY:0] sel_pipe;

    assign in_range_c   = {1'b0, ray_address_in} < 17'(FRAME_PIXELS);
    assign swap_event_c = (hcount_in == '0) && (vcount_in == 10'(FULL_SCREEN_HEIGHT));

    assign active_c  = (hcount_in < 11'(FULL_SCREEN_WIDTH)) && (vcount_in < 10'(FULL_SCREEN_HEIGHT));
    assign rd_addr_c = 16'(EXT_W'(hcount_in >> SCALE_SHIFT)
                         + EXT_W'(vcount_in >> SCALE_SHIFT) * EXT_W'(SCREEN_WIDTH));

    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= WRITING;
        end else begin
            state <= state_next;
        end
    end

    // Write acceptance, drop detection and swap decision.
    always_comb begin
        state_next = state;
        ready_next = 1'b1;
        accept_c   = 1'b0;
        drop_c     = 1'b0;
        sel_next   = display_sel_out;
        count_next = frame_count_out;
        case (state)
            WRITING: begin
                if (ray_valid_in) begin
                    if (in_range_c) begin
                        accept_c = 1'b1;
                        if (ray_last_pixel_in) begin
                            state_next = WAIT_SWAP;
                            ready_next = 1'b0;
                        end
                    end else begin
                        drop_c = 1'b1;
                    end
                end
            end
            WAIT_SWAP: begin
                ready_next = 1'b0;
                drop_c     = ray_valid_in;
                if (swap_event_c) begin
                    state_next = WRITING;
                    ready_next = 1'b1;
                    sel_next   = ~display_sel_out;
                    count_next = frame_count_out + 8'd1;
                end
            end
            default: state_next = WRITING;
        endcase
    end

    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            frame_buff_ready_out <= 1'b1;
            wr_en_a_out          <= 1'b0;
            wr_en_b_out          <= 1'b0;
            wr_addr_out          <= '0;
            wr_data_out          <= '0;
            display_sel_out      <= 1'b0;
            frame_count_out      <= '0;
            drop_flag_out        <= 1'b0;
        end else begin
            frame_buff_ready_out <= ready_next;
            wr_en_a_out          <= accept_c & display_sel_out;
            wr_en_b_out          <= accept_c & ~display_sel_out;
            if (accept_c) begin
                wr_addr_out <= ray_address_in;
                wr_data_out <= ray_pixel_in;
            end
            display_sel_out <= sel_next;
            frame_count_out <= count_next;
            drop_flag_out   <= drop_flag_out | drop_c;
        end
    end

    // Read side: active flag and bank select travel with the address through BRAM latency.
    always_ff @(posedge pixel_clk_in or posedge rst_in) begin
        if (rst_in) begin
            rd_addr_out <= '0;
            act_pipe    <= '0;
            sel_pipe    <= '0;
            pixel_out   <= '0;
        end else begin
            rd_addr_out <= rd_addr_c;
            act_pipe    <= {act_pipe[RD_LATENCY-1:0], active_c};
            sel_pipe    <= {sel_pipe[RD_LATENCY-1:0], display_sel_out};
            if (!act_pipe[RD_LATENCY]) begin
                pixel_out <= '0;
            end else if (sel_pipe[RD_LATENCY]) begin
                pixel_out <= rd_data_b_in;
            end else begin
                pixel_out <= rd_data_a_in;
            end
        end
    end

endmodule

// File: tb/tb_frame_buffer_swap.sv
// Bench for frame_buffer_swap: two BRAM banks with 2-cycle read latency around the DUT,
// and a frame-level reference model of bank contents, swap state and display pixels.
module tb_frame_buffer_swap;

    logic        clk = 1'b0;
    logic        rst;
    logic        ray_valid;
    logic [15:0] ray_address;
    logic [15:0] ray_pixel;
    logic        ray_last;
    logic        ready;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        wr_en_a;
    logic        wr_en_b;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
    logic [15:0] rd_addr;
    logic [15:0] rd_data_a;
    logic [15:0] rd_data_b;
    logic [15:0] pixel;
    logic        display_sel;
    logic [7:0]  frame_count;
    logic        drop_flag;

    always #5 clk = ~clk;

    frame_buffer_swap dut (
        .pixel_clk_in         (clk),
        .rst_in               (rst),
        .ray_valid_in         (ray_valid),
        .ray_address_in       (ray_address),
        .ray_pixel_in         (ray_pixel),
        .ray_last_pixel_in    (ray_last),
        .frame_buff_ready_out (ready),
        .hcount_in            (hcount),
        .vcount_in            (vcount),
        .wr_en_a_out          (wr_en_a),
        .wr_en_b_out          (wr_en_b),
        .wr_addr_out          (wr_addr),
        .wr_data_out          (wr_data),
        .rd_addr_out          (rd_addr),
        .rd_data_a_in         (rd_data_a),
        .rd_data_b_in         (rd_data_b),
        .pixel_out            (pixel),
        .display_sel_out      (display_sel),
        .frame_count_out      (frame_count),
        .drop_flag_out        (drop_flag)
    );

    // External BRAM banks driven by the DUT.
    logic [15:0] bram_a [0:65535];
    logic [15:0] bram_b [0:65535];
    logic [15:0] pipe_a;
    logic [15:0] pipe_b;

    always @(posedge clk) begin
        pipe_a    <= bram_a[rd_addr];
        pipe_b    <= bram_b[rd_addr];
        rd_data_a <= pipe_a;
        rd_data_b <= pipe_b;
        if (wr_en_a) bram_a[wr_addr] <= wr_data;
        if (wr_en_b) bram_b[wr_addr] <= wr_data;
    end

    // Reference model.
    logic [15:0] ref_a [0:65535];
    logic [15:0] ref_b [0:65535];
    logic        m_sel;
    logic        m_wait;
    logic        m_drop;
    int          m_count;
    logic [15:0] pix_q [$];

    int checks = 0;
    int errors = 0;
    int wr_a_seen = 0;
    int wr_b_seen = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] rand_h();
        return 11'($urandom_range(1280, 2047));
    endfunction

    task automatic model_reset();
        m_sel   = 1'b0;
        m_wait  = 1'b0;
        m_drop  = 1'b0;
        m_count = 0;
        pix_q.delete();
        repeat (3) pix_q.push_back(16'h0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ready"}, 32'(ready), 32'd1);
        chk({tag, "_wr_en_a"}, 32'(wr_en_a), 32'd0);
        chk({tag, "_wr_en_b"}, 32'(wr_en_b), 32'd0);
        chk({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
        chk({tag, "_wr_data"}, 32'(wr_data), 32'd0);
        chk({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
        chk({tag, "_pixel"}, 32'(pixel), 32'd0);
        chk({tag, "_sel"}, 32'(display_sel), 32'd0);
        chk({tag, "_count"}, 32'(frame_count), 32'd0);
        chk({tag, "_drop"}, 32'(drop_flag), 32'd0);
    endtask

    // One clock of stimulus, then check every output against the model.
    task automatic step(input logic v, input logic [15:0] a, input logic [15:0] p,
                        input logic l, input logic [10:0] h, input logic [9:0] vc);
        logic        acc;
        logic        sw;
        logic        pre_sel;
        logic        active;
        logic [15:0] eaddr;
        logic [15:0] epix;
        int          ia;
        ray_valid   = v;
        ray_address = a;
        ray_pixel   = p;
        ray_last    = l;
        hcount      = h;
        vcount      = vc;
        active  = (int'(h) < 1280) && (int'(vc) < 720);
        ia      = int'(h) / 4 + (int'(vc) / 4) * 320;
        eaddr   = 16'(ia);
        epix    = !active ? 16'h0 : (m_sel ? ref_b[eaddr] : ref_a[eaddr]);
        pre_sel = m_sel;
        acc     = !m_wait && v && (int'(a) < 57600);
        sw      = m_wait && (h == 11'd0) && (vc == 10'd720);
        @(posedge clk);
        #1;
        if (acc) begin
            if (pre_sel) ref_a[a] = p;
            else         ref_b[a] = p;
            if (l) m_wait = 1'b1;
        end else if (v) begin
            m_drop = 1'b1;
        end
        if (sw) begin
            m_sel   = ~m_sel;
            m_count = (m_count + 1) % 256;
            m_wait  = 1'b0;
        end
        if (wr_en_a) wr_a_seen++;
        if (wr_en_b) wr_b_seen++;
        chk("wr_en_a", 32'(wr_en_a), 32'(acc && pre_sel));
        chk("wr_en_b", 32'(wr_en_b), 32'(acc && !pre_sel));
        if (acc) begin
            chk("wr_addr", 32'(wr_addr), 32'(a));
            chk("wr_data", 32'(wr_data), 32'(p));
        end
        chk("ready", 32'(ready), 32'(!m_wait));
        chk("display_sel", 32'(display_sel), 32'(m_sel));
        chk("frame_count", 32'(frame_count), 32'(m_count));
        chk("drop_flag", 32'(drop_flag), 32'(m_drop));
        chk("rd_addr", 32'(rd_addr), 32'(eaddr));
        pix_q.push_back(epix);
        if (pix_q.size() >= 4) begin
            chk("pixel_out", 32'(pixel), 32'(pix_q[0]));
            void'(pix_q.pop_front());
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 16'h0, 16'h0, 1'b0, rand_h(), 10'($urandom_range(0, 1023)));
    endtask

    task automatic boundary();
        step(1'b0, 16'h0, 16'h0, 1'b0, 11'd0, 10'd720);
    endtask

    task automatic random_reads(input int n);
        repeat (n) step(1'b0, 16'h0, 16'h0, 1'b0, 11'($urandom_range(0, 2047)),
                        10'($urandom_range(0, 1023)));
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            bram_a[i] = 16'h0;
            bram_b[i] = 16'h0;
            ref_a[i]  = 16'h0;
            ref_b[i]  = 16'h0;
        end
        rst         = 1'b1;
        ray_valid   = 1'b0;
        ray_address = 16'h0;
        ray_pixel   = 16'h0;
        ray_last    = 1'b0;
        hcount      = 11'd0;
        vcount      = 10'd0;
        #12;
        check_reset_vals("reset");
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Full frame into bank B, then swap at the frame boundary.
        for (int i = 0; i < 57600; i++) begin
            step(1'b1, 16'(i), 16'(i), 1'(i == 57599), 11'd1500, 10'd0);
        end
        chk("ready_after_last", 32'(ready), 32'd0);
        idle(3);
        boundary();
        chk("wr_b_pulses", 32'(wr_b_seen), 32'd57600);
        chk("wr_a_pulses", 32'(wr_a_seen), 32'd0);
        chk("sel_after_swap", 32'(display_sel), 32'd1);
        chk("count_after_swap", 32'(frame_count), 32'd1);

        // Upscaled read of the new front bank.
        step(1'b0, 16'h0, 16'h0, 1'b0, 11'd8, 10'd4);
        chk("rd_addr_8_4", 32'(rd_addr), 32'd322);
        repeat (3) step(1'b0, 16'h0, 16'h0, 1'b0, 11'd1300, 10'd100);
        chk("pixel_8_4", 32'(pixel), 32'd322);
        repeat (3) step(1'b0, 16'h0, 16'h0, 1'b0, 11'd1300, 10'd100);
        chk("pixel_inactive", 32'(pixel), 32'd0);
        random_reads(200);

        // Out-of-range write is dropped and the flag sticks.
        step(1'b1, 16'd60000, 16'hbeef, 1'b0, 11'd1500, 10'd0);
        chk("drop_set", 32'(drop_flag), 32'd1);
        idle(5);

        // Last pixel coincides with the boundary: swap deferred to the next boundary.
        for (int i = 0; i < 10; i++) begin
            if (i == 9) step(1'b1, 16'(i), 16'($urandom), 1'b1, 11'd0, 10'd720);
            else        step(1'b1, 16'(i), 16'($urandom), 1'b0, 11'd1500, 10'd0);
        end
        chk("no_swap_coincident", 32'(display_sel), 32'd1);
        idle(4);
        boundary();
        chk("deferred_swap_sel", 32'(display_sel), 32'd0);
        chk("deferred_swap_count", 32'(frame_count), 32'd2);

        // Randomized short frames with gaps, drops and spurious boundaries.
        for (int f = 0; f < 30; f++) begin
            int n;
            n = int'($urandom_range(1, 40));
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 3) == 0) idle(1);
                if ($urandom_range(0, 9) == 0)
                    step(1'b1, 16'($urandom_range(57600, 65535)), 16'($urandom), 1'b0, rand_h(), 10'd0);
                if ($urandom_range(0, 9) == 0) boundary();
                step(1'b1, 16'($urandom_range(0, 57599)), 16'($urandom), 1'(k == n - 1),
                     rand_h(), 10'($urandom_range(0, 1023)));
            end
            repeat ($urandom_range(0, 4))
                step(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 1'b0, rand_h(), 10'd0);
            boundary();
        end
        random_reads(300);

        // Asynchronous reset in the middle of a frame.
        for (int i = 0; i < 5; i++) step(1'b1, 16'(i + 100), 16'($urandom), 1'b0, 11'd1500, 10'd0);
        idle(1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_vals("async_reset");
        #11;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 16'(i * 7), 16'($urandom), 1'(i == 19), 11'd1500, 10'd0);
        end
        idle(2);
        boundary();
        chk("post_reset_sel", 32'(display_sel), 32'd1);
        chk("post_reset_count", 32'(frame_count), 32'd1);
        random_reads(100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
